pot_scan_sequencer: RTL and testbench

Round-robin scheduler owning the slide-potentiometer A2D path of the equalizer. It sequences a shared 16-bit SPI master through two-transaction conversions on the ADC128S for six pots: LP, B1, B2, B3, HP and volume. It latches each 12-bit result into a dedicated output register consumed by the band-gain and volume datapath. It is the only requester of the SPI master.

---
 rtl/pot_scan_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_pot_scan_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pot_scan_sequencer.sv
// pot_scan_sequencer
//    Round-robin scheduler for the six slide-pot A2D conversions (LP, B1,
//    B2, B3, HP, volume). Each conversion is two SPI transactions on the
//    ADC128S: a channel-select, a settle wait, then a read of the same
//    channel. Results land in one output register per pot.
//
//    Parameters
//       SETTLE_CYCLES   idle cycles between select-done and read-wrt (>= 1)
//       SCAN_GAP        idle cycles after a full sweep (>= 1)
//
//    Ports
//       clk             system clock
//       rst_n           synchronous active-low reset
//       scan_en         sweeping allowed; on drop, finish current pot then park
//       wrt / cmd       start strobe and command word to the SPI master
//       done / rd_data  SPI completion pulse and receive word (result in [11:0])
//       *_pot, volume   latched 12-bit pot values
//       pot_vld/pot_idx one-cycle update pulse and the index updated
//       sweep_done      pulse after the volume register updates
//
//    Build option
//       POT_SMOOTH_EN   when defined, each store applies a 1/4 IIR step toward
//                       the new sample (the first store after reset loads raw)
//
//    state    | meaning
//    ---------+-------------------------------------------------------
//    S_IDLE   | parked; start a conversion at idx when scan_en is high
//    S_SEL    | channel-select transaction outstanding, wait for done
//    S_SETTLE | down-counting settle time before the read transaction
//    S_RD     | read transaction outstanding, capture rd_data on done
//    S_STORE  | write pot register, advance idx, chain or park
//    S_GAP    | down-counting inter-sweep gap
module pot_scan_sequencer #(
   parameter int SETTLE_CYCLES = 32,
   parameter int SCAN_GAP      = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_en,
   output logic        wrt,
   output logic [15:0] cmd,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic [11:0] LP_pot,
   output logic [11:0] B1_pot,
   output logic [11:0] B2_pot,
   output logic [11:0] B3_pot,
   output logic [11:0] HP_pot,
   output logic [11:0] volume,
   output logic        pot_vld,
   output logic [2:0]  pot_idx,
   output logic        sweep_done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SEL    = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_RD     = 3'd3;
   localparam logic [2:0] S_STORE  = 3'd4;
   localparam logic [2:0] S_GAP    = 3'd5;

   localparam int CNT_MAX = (SETTLE_CYCLES > SCAN_GAP) ? SETTLE_CYCLES : SCAN_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(SCAN_GAP - 1);

   logic [2:0]       state_q;
   logic [2:0]       idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic [11:0]      sample_q;
   logic [11:0]      pot_q [6];
   logic [11:0]      new_val;

   // upper nibble of the receive word carries no conversion data
   logic unused_rd_hi;
   assign unused_rd_hi = ^rd_data[15:12];

   // board wiring of pots to ADC inputs is not in index order
   function automatic logic [15:0] cmd_word(input logic [2:0] i);
      logic [2:0] ch;
      case (i)
         3'd0:    ch = 3'd1;
         3'd1:    ch = 3'd0;
         3'd2:    ch = 3'd4;
         3'd3:    ch = 3'd2;
         3'd4:    ch = 3'd3;
         default: ch = 3'd7;
      endcase
      return {2'b00, ch, 11'h000};
   endfunction

`ifdef POT_SMOOTH_EN
   logic [5:0]         init_q;
   logic [11:0]        old_val;
   logic               old_init;
   logic signed [12:0] old_s;
   logic signed [12:0] diff_s;
   logic signed [12:0] sum_s;

   always_comb begin
      old_val  = '0;
      old_init = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (idx_q == 3'(i)) begin
            old_val  = pot_q[i];
            old_init = init_q[i];
         end
      end
      old_s   = $signed({1'b0, old_val});
      diff_s  = $signed({1'b0, sample_q}) - old_s;
      sum_s   = old_s + (diff_s >>> 2);
      new_val = old_init ? sum_s[11:0] : sample_q;
   end
`else
   always_comb begin
      new_val = sample_q;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         sample_q   <= '0;
         wrt        <= 1'b0;
         cmd        <= '0;
         pot_vld    <= 1'b0;
         pot_idx    <= '0;
         sweep_done <= 1'b0;
         for (int i = 0; i < 6; i++) pot_q[i] <= '0;
`ifdef POT_SMOOTH_EN
         init_q     <= '0;
`endif
      end else begin
         wrt        <= 1'b0;
         pot_vld    <= 1'b0;
         sweep_done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (scan_en) begin
                  state_q <= S_SEL;
                  wrt     <= 1'b1;
                  cmd     <= cmd_word(idx_q);
               end
            end
            S_SEL: begin
               if (done) begin
                  state_q <= S_SETTLE;
                  cnt_q   <= SETTLE_LOAD;
               end
            end
            S_SETTLE: begin
               if (cnt_q == '0) begin
                  state_q <= S_RD;
                  wrt     <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_RD: begin
               if (done) begin
                  state_q  <= S_STORE;
                  sample_q <= rd_data[11:0];
               end
            end
            S_STORE: begin
               for (int i = 0; i < 6; i++) begin
                  if (idx_q == 3'(i)) begin
                     pot_q[i] <= new_val;
`ifdef POT_SMOOTH_EN
                     init_q[i] <= 1'b1;
`endif
                  end
               end
               pot_vld <= 1'b1;
               pot_idx <= idx_q;
               if (idx_q == 3'd5) begin
                  idx_q      <= '0;
                  sweep_done <= 1'b1;
                  state_q    <= S_GAP;
                  cnt_q      <= GAP_LOAD;
               end else begin
                  idx_q <= idx_q + 3'd1;
                  // chaining straight into SEL saves an IDLE cycle per pot
                  if (scan_en) begin
                     state_q <= S_SEL;
                     wrt     <= 1'b1;
                     cmd     <= cmd_word(idx_q + 3'd1);
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_GAP: begin
               if (cnt_q == '0) state_q <= S_IDLE;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign LP_pot = pot_q[0];
   assign B1_pot = pot_q[1];
   assign B2_pot = pot_q[2];
   assign B3_pot = pot_q[3];
   assign HP_pot = pot_q[4];
   assign volume = pot_q[5];

endmodule

// File: tb/tb_pot_scan_sequencer.sv
module tb_pot_scan_sequencer;

   localparam int SETTLE = 32;
   localparam int GAP    = 1024;
   localparam int T_SPI  = 40;

   logic        clk;
   logic        rst_n;
   logic        scan_en;
   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [15:0] rd_data;
   logic [11:0] LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, volume;
   logic        pot_vld;
   logic [2:0]  pot_idx;
   logic        sweep_done;

   logic        model_done;
   logic        inj_done;
   logic [11:0] ofs;

   assign done = model_done | inj_done;

   pot_scan_sequencer #(.SETTLE_CYCLES(SETTLE), .SCAN_GAP(GAP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_en    (scan_en),
      .wrt        (wrt),
      .cmd        (cmd),
      .done       (done),
      .rd_data    (rd_data),
      .LP_pot     (LP_pot),
      .B1_pot     (B1_pot),
      .B2_pot     (B2_pot),
      .B3_pot     (B3_pot),
      .HP_pot     (HP_pot),
      .volume     (volume),
      .pot_vld    (pot_vld),
      .pot_idx    (pot_idx),
      .sweep_done (sweep_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [11:0] get_pot(input logic [2:0] i);
      case (i)
         3'd0:    return LP_pot;
         3'd1:    return B1_pot;
         3'd2:    return B2_pot;
         3'd3:    return B3_pot;
         3'd4:    return HP_pot;
         default: return volume;
      endcase
   endfunction

   function automatic logic [11:0] exp_store(input logic [11:0] old, input logic [11:0] s, input bit first);
`ifdef POT_SMOOTH_EN
      int d;
      if (first) return s;
      d = int'(s) - int'(old);
      return 12'(int'(old) + (d >>> 2));
`else
      if (first || old == old) return s;
      return s;
`endif
   endfunction

   // SPI master model plus output monitor, evaluated on the falling edge
   int          wrt_cyc [$];
   logic [15:0] cmd_log [$];
   int          done_log [$];
   logic [2:0]  vld_log [$];
   int          n_vld   = 0;
   int          n_sweep = 0;
   int          sweep_cyc = 0;
   bit          pend = 0;
   int          elapsed = 0;
   logic [2:0]  chn = '0;
   logic [11:0] last_sample = '0;
   logic [11:0] exp_pot [6];
   bit          exp_init [6];
   logic [2:0]  exp_idx = '0;

   always @(negedge clk) begin
      model_done = 1'b0;
      if (!rst_n) begin
         pend    = 0;
         exp_idx = '0;
         for (int i = 0; i < 6; i++) begin
            exp_pot[i]  = '0;
            exp_init[i] = 0;
         end
      end else begin
         if (pend) begin
            elapsed++;
            if (elapsed == T_SPI) begin
               model_done  = 1'b1;
               rd_data     = {4'h0, 12'hA00 + {9'h0, chn} + ofs};
               last_sample = rd_data[11:0];
               pend        = 0;
               done_log.push_back(cyc);
            end
         end
         if (wrt) begin
            check("wrt_while_busy", {31'h0, pend}, 32'h0);
            pend    = 1;
            elapsed = 0;
            chn     = cmd[13:11];
            wrt_cyc.push_back(cyc);
            cmd_log.push_back(cmd);
         end
         if (pot_vld) begin
            check("pot_idx_seq", {29'h0, pot_idx}, {29'h0, exp_idx});
            exp_pot[exp_idx]  = exp_store(exp_pot[exp_idx], last_sample, !exp_init[exp_idx]);
            exp_init[exp_idx] = 1;
            check("pot_value", {20'h0, get_pot(pot_idx)}, {20'h0, exp_pot[exp_idx]});
            vld_log.push_back(pot_idx);
            n_vld++;
            exp_idx = (exp_idx == 3'd5) ? 3'd0 : exp_idx + 3'd1;
         end
         if (sweep_done) begin
            check("sweep_with_vol", {31'h0, pot_vld && pot_idx == 3'd5}, 32'h1);
            sweep_cyc = cyc;
            n_sweep++;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic inject_done();
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
   endtask

   task automatic wait_wrt(input int n, input int limit, input string nm);
      int k = 0;
      while (wrt_cyc.size() < n && k < limit) begin tick(); k++; end
      check(nm, {31'h0, wrt_cyc.size() >= n}, 32'h1);
   endtask

   task automatic wait_vld(input int n, input int limit, input string nm);
      int k = 0;
      while (n_vld < n && k < limit) begin tick(); k++; end
      check(nm, {31'h0, n_vld >= n}, 32'h1);
   endtask

   task automatic wait_sweeps(input int n, input int limit, input string nm);
      int k = 0;
      while (n_sweep < n && k < limit) begin tick(); k++; end
      check(nm, {31'h0, n_sweep >= n}, 32'h1);
   endtask

   typedef struct {
      logic [2:0]  idx;
      logic [15:0] cmd;
      logic [11:0] pot;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{3'd0, 16'h0800, 12'hA01};
      tbl[1] = '{3'd1, 16'h0000, 12'hA00};
      tbl[2] = '{3'd2, 16'h2000, 12'hA04};
      tbl[3] = '{3'd3, 16'h1000, 12'hA02};
      tbl[4] = '{3'd4, 16'h1800, 12'hA03};
      tbl[5] = '{3'd5, 16'h3800, 12'hA07};

      rst_n    = 1'b0;
      scan_en  = 1'b1;
      inj_done = 1'b0;
      ofs      = '0;
      rd_data  = '0;
      repeat (3) tick();

      check("rst_wrt",        {31'h0, wrt}, 32'h0);
      check("rst_cmd",        {16'h0, cmd}, 32'h0);
      check("rst_pot_vld",    {31'h0, pot_vld}, 32'h0);
      check("rst_sweep_done", {31'h0, sweep_done}, 32'h0);
      check("rst_pot_idx",    {29'h0, pot_idx}, 32'h0);
      for (int i = 0; i < 6; i++) check("rst_pot", {20'h0, get_pot(3'(i))}, 32'h0);

      // sweep 1: command sequence, results, index order, settle spacing
      rst_n = 1'b1;
      wait_sweeps(1, 3000, "sweep1_timeout");
      check("sweep1_wrt_count", wrt_cyc.size(), 12);
      check("sweep1_vld_count", n_vld, 6);
      for (int i = 0; i < 6; i++) begin
         check("sel_cmd",   {16'h0, cmd_log[2*i]},   {16'h0, tbl[i].cmd});
         check("rd_cmd",    {16'h0, cmd_log[2*i+1]}, {16'h0, tbl[i].cmd});
         check("vld_order", {29'h0, vld_log[i]},     {29'h0, tbl[i].idx});
         check("sweep1_pot", {20'h0, get_pot(tbl[i].idx)}, {20'h0, tbl[i].pot});
         check("settle_gap", {31'h0, (wrt_cyc[2*i+1] - done_log[2*i]) >= SETTLE + 1}, 32'h1);
      end

      // done during GAP is ignored; next sweep starts SCAN_GAP+1 after sweep_done
      repeat (100) tick();
      inject_done();
      ofs = 12'h100;
      wait_wrt(13, 1500, "sweep2_start_timeout");
      check("sweep_spacing", wrt_cyc[12] - sweep_cyc, GAP + 1);
      check("sweep2_first_cmd", {16'h0, cmd_log[12]}, 32'h0800);
      check("gap_no_vld", n_vld, 6);
      check("sweep_done_once", n_sweep, 1);

      // drop scan_en in idx 2 SETTLE, with a stray done in SETTLE too
      wait_wrt(17, 400, "idx2_sel_timeout");
      repeat (45) tick();
      inject_done();
      scan_en = 1'b0;
      wait_vld(9, 200, "idx2_store_timeout");
      check("b2_idx", {29'h0, vld_log[8]}, 32'h2);
      check("b2_value", {20'h0, B2_pot}, {20'h0, exp_store(12'hA04, 12'hB04, 1'b0)});
      check("settle_exact", wrt_cyc[17] - done_log[16], SETTLE + 1);
      repeat (100) tick();
      check("parked_no_wrt", wrt_cyc.size(), 18);
      check("parked_no_vld", n_vld, 9);
      scan_en = 1'b1;
      wait_wrt(19, 10, "resume_timeout");
      check("resume_cmd", {16'h0, cmd_log[18]}, 32'h1000);

      // one-cycle reset in the middle of the idx 3 read transaction
      wait_wrt(20, 200, "idx3_rd_timeout");
      repeat (10) tick();
      rst_n = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) check("midrd_rst_pot", {20'h0, get_pot(3'(i))}, 32'h0);
      check("midrd_rst_wrt", {31'h0, wrt}, 32'h0);
      rst_n = 1'b1;
      wait_wrt(21, 10, "post_rst_wrt_timeout");
      check("post_rst_cmd", {16'h0, cmd_log[20]}, 32'h0800);

      // full sweep from reset with offset data
      wait_sweeps(2, 3000, "sweep3_timeout");
      check("sweep3_vld_count", n_vld, 15);
      for (int i = 0; i < 6; i++)
         check("sweep3_pot", {20'h0, get_pot(tbl[i].idx)}, {20'h0, tbl[i].pot + 12'h100});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
